shift_add_mult_ctrl: RTL

//  Parametrised control FSM for the shift-add (signed/unsigned) multiplier datapath.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 19 +
 rtl/shift_add_mult_ctrl_iter_counter.sv | 36 +++
 rtl/shift_add_mult_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and helpers for the shift-add multiplier controller.
// State encoding is fixed so that unused codes (6, 7) are recognisable as illegal.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    HALT  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } ctrl_state_t;

  // Width of the iteration index; a 1-bit floor keeps WIDTH=2 legal.
  function automatic int cnt_w(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_iter_counter.sv
// Iteration index for the multiplier sequence: synchronous clear, saturating increment,
// and a terminal-count flag when the index reaches WIDTH-1.
module iter_counter
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    i_clr,
  input  logic                    i_inc,
  output logic [cnt_w(WIDTH)-1:0] o_count,
  output logic                    o_last
);

  localparam int              CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == LAST);

  // Saturates at LAST so the index never wraps even if inc is held.
  always_ff @(posedge Clk) begin
    if (Reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_last) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = w_last;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the shift-add multiplier: load, clear, WIDTH add/sub+shift steps, done handshake.
//  state | meaning
//  HALT  | idle, all outputs low; Run starts a job, ClearA_LoadB loads B
//  LOAD  | one-cycle Clr_Ld pulse, back to HALT
//  START | clear A/X, reset iteration index
//  ADD   | add (or subtract on the signed last step) when M=1, idle slot when M=0
//  SHIFT | shift X:A:B right, advance index or finish
//  DONE  | result valid; held until Run drops
module shift_add_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Run,
  input  logic                    ClearA_LoadB,
  input  logic                    Signed_Mode,
  input  logic                    M,
  output logic                    Clr_Ld,
  output logic                    ClearA,
  output logic                    Add,
  output logic                    Sub,
  output logic                    Shift,
  output logic                    Ext_Sign,
  output logic                    Busy,
  output logic                    Done,
  output logic [cnt_w(WIDTH)-1:0] Count
);

  ctrl_state_t r_state;
  ctrl_state_t w_next_state;
  logic        r_ext_sign;
  logic        w_ext_sign_next;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_last;

  iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_count (Count),
    .o_last  (w_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= HALT;
      r_ext_sign <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ext_sign <= w_ext_sign_next;
    end
  end

  // Mode is captured only on the HALT->START edge and dropped on return to HALT.
  always_comb begin
    w_next_state    = r_state;
    w_ext_sign_next = r_ext_sign;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    case (r_state)
      HALT: begin
        if (Run) begin
          w_next_state    = START;
          w_ext_sign_next = Signed_Mode;
        end else if (ClearA_LoadB) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        w_next_state = HALT;
      end
      START: begin
        w_cnt_clr    = 1'b1;
        w_next_state = ADD;
      end
      ADD: begin
        w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_cnt_inc    = 1'b1;
          w_next_state = ADD;
        end
      end
      DONE: begin
        if (!Run) begin
          w_next_state    = HALT;
          w_ext_sign_next = 1'b0;
          w_cnt_clr       = 1'b1;
        end
      end
      default: begin
        w_next_state    = HALT;
        w_ext_sign_next = 1'b0;
        w_cnt_clr       = 1'b1;
      end
    endcase
  end

  always_comb begin
    Clr_Ld = 1'b0;
    ClearA = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      LOAD: begin
        Clr_Ld = 1'b1;
      end
      START: begin
        ClearA = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        if (M) begin
          if (w_last && r_ext_sign) begin
            Sub = 1'b1;
          end else begin
            Add = 1'b1;
          end
        end
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign Ext_Sign = r_ext_sign;

endmodule
